// File: rtl/mem_access_unit_if.sv
// Request, response and data-memory bus bundle for mem_access_unit.
// slave is the unit's view; master is the pipeline/memory environment's view.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) ();
  logic              req_valid;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [DATA_W-1:0] req_data2;
  logic              req_ready;
  logic              stall;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_word;
  logic [ADDR_W-1:0] sp;
  logic              stack_exc;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  req_valid, req_op, req_addr, req_data, req_data2, mem_read_data,
    output req_ready, stall, resp_valid, resp_data, resp_word, sp, stack_exc,
           mem_address, mem_write_data, mem_read, mem_write
  );

  modport master (
    output req_valid, req_op, req_addr, req_data, req_data2, mem_read_data,
    input  req_ready, stall, resp_valid, resp_data, resp_word, sp, stack_exc,
           mem_address, mem_write_data, mem_read, mem_write
  );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory initiator: load/store/stack ops, owns the stack pointer, splits PUSH2/POP2.
// Optional stack bound checking is enabled by defining STACK_CHECK_EN.
module mem_access_unit #(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DATA_W      = 16,
  parameter logic [ADDR_W-1:0] SP_RESET    = 16'h0FFF,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = 16'h0800
) (
  input logic             clk,
  input logic             rst_n,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAcc1, StAcc2, StResp} state_e;
  typedef enum logic [2:0] {
    OpNop   = 3'd0,
    OpLoad  = 3'd1,
    OpStore = 3'd2,
    OpPush  = 3'd3,
    OpPop   = 3'd4,
    OpPush2 = 3'd5,
    OpPop2  = 3'd6,
    OpRsvd  = 3'd7
  } op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d, req_op;
  logic [ADDR_W-1:0] sp_q, sp_d, addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, data2_q, data2_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic              rv_q, rv_d, rw_q, rw_d, exc_q, exc_d;
  logic              ready;
  logic              push_bad, push2_bad, pop_bad, pop2_bad;

  assign req_op = op_e'(bus.req_op);
  assign ready  = (state_q == StIdle);

`ifdef STACK_CHECK_EN
  logic [ADDR_W:0] sp_ext, lim_ext, top_ext;
  assign sp_ext  = {1'b0, sp_q};
  assign lim_ext = {1'b0, STACK_LIMIT};
  assign top_ext = {1'b0, SP_RESET};
  // Extended-width compares so the bound checks themselves cannot wrap.
  assign push_bad  = (sp_ext < lim_ext) || (sp_q == '0);
  assign push2_bad = (sp_ext < (lim_ext + (ADDR_W+1)'(1))) || (sp_q < ADDR_W'(2));
  assign pop_bad   = ((sp_ext + (ADDR_W+1)'(1)) > top_ext);
  assign pop2_bad  = ((sp_ext + (ADDR_W+1)'(2)) > top_ext);
`else
  logic unused_limit;
  assign unused_limit = ^STACK_LIMIT;
  assign push_bad  = 1'b0;
  assign push2_bad = 1'b0;
  assign pop_bad   = 1'b0;
  assign pop2_bad  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sp_d    = sp_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data2_d = data2_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    rv_d    = 1'b0;
    rw_d    = 1'b0;
    exc_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          op_d = req_op;
          case (req_op)
            OpLoad: begin
              addr_d  = bus.req_addr;
              rd_d    = 1'b1;
              state_d = StAcc1;
            end
            OpStore: begin
              addr_d  = bus.req_addr;
              wdata_d = bus.req_data;
              wr_d    = 1'b1;
              state_d = StAcc1;
            end
            OpPush: begin
              if (push_bad) begin
                exc_d = 1'b1;
              end else begin
                addr_d  = sp_q;
                wdata_d = bus.req_data;
                wr_d    = 1'b1;
                sp_d    = sp_q - ADDR_W'(1);
                state_d = StAcc1;
              end
            end
            OpPop: begin
              if (pop_bad) begin
                exc_d = 1'b1;
              end else begin
                addr_d  = sp_q + ADDR_W'(1);
                rd_d    = 1'b1;
                sp_d    = sp_q + ADDR_W'(1);
                state_d = StAcc1;
              end
            end
            OpPush2: begin
              if (push2_bad) begin
                exc_d = 1'b1;
              end else begin
                addr_d  = sp_q;
                wdata_d = bus.req_data;
                data2_d = bus.req_data2;
                wr_d    = 1'b1;
                sp_d    = sp_q - ADDR_W'(2);
                state_d = StAcc1;
              end
            end
            OpPop2: begin
              if (pop2_bad) begin
                exc_d = 1'b1;
              end else begin
                addr_d  = sp_q + ADDR_W'(1);
                rd_d    = 1'b1;
                sp_d    = sp_q + ADDR_W'(2);
                state_d = StAcc1;
              end
            end
            default: ;
          endcase
        end
      end
      StAcc1: begin
        case (op_q)
          OpPush2: begin
            addr_d  = addr_q - ADDR_W'(1);
            wdata_d = data2_q;
            wr_d    = 1'b1;
            state_d = StAcc2;
          end
          OpPop2: begin
            // First word (flags) is returned while the second read is in flight.
            addr_d  = addr_q + ADDR_W'(1);
            rd_d    = 1'b1;
            rv_d    = 1'b1;
            state_d = StAcc2;
          end
          OpLoad, OpPop: begin
            rv_d    = 1'b1;
            state_d = StResp;
          end
          default: state_d = StIdle;
        endcase
      end
      StAcc2: begin
        if (op_q == OpPop2) begin
          rv_d    = 1'b1;
          rw_d    = 1'b1;
          state_d = StResp;
        end else begin
          state_d = StIdle;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= OpNop;
      sp_q    <= SP_RESET;
      addr_q  <= '0;
      wdata_q <= '0;
      data2_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rv_q    <= 1'b0;
      rw_q    <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sp_q    <= sp_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data2_q <= data2_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rv_q    <= rv_d;
      rw_q    <= rw_d;
      exc_q   <= exc_d;
    end
  end

  assign bus.req_ready      = ready;
  assign bus.stall          = bus.req_valid & ~ready;
  assign bus.resp_valid     = rv_q;
  assign bus.resp_word      = rw_q;
  assign bus.resp_data      = bus.mem_read_data;
  assign bus.sp             = sp_q;
  assign bus.stack_exc      = exc_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.mem_read       = rd_q;
  assign bus.mem_write      = wr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a 4K-word registered-read memory model.
module tb_mem_access_unit;

  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_PUSH  = 3'd3;
  localparam logic [2:0] OP_POP   = 3'd4;
  localparam logic [2:0] OP_PUSH2 = 3'd5;
  localparam logic [2:0] OP_POP2  = 3'd6;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;
  int   wr_cnt = 0;
  int   w0;

  logic [15:0] mem [0:4095];
  logic [15:0] rdata;

  mem_access_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_access_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_write) begin
      mem[bus.mem_address[11:0]] <= bus.mem_write_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.mem_read) rdata <= mem[bus.mem_address[11:0]];
  end
  assign bus.mem_read_data = rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a request at the current negedge; return at the negedge after its accept edge.
  task automatic present(input logic [2:0] op, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] d2);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_data2 = d2;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_data2 = '0;
    repeat (3) @(negedge clk);

    check("rst_ready", 32'(bus.req_ready), 1);
    check("rst_rd", 32'(bus.mem_read), 0);
    check("rst_wr", 32'(bus.mem_write), 0);
    check("rst_rv", 32'(bus.resp_valid), 0);
    check("rst_exc", 32'(bus.stack_exc), 0);
    check("rst_addr", 32'(bus.mem_address), 'h0000);
    check("rst_wdata", 32'(bus.mem_write_data), 'h0000);
    check("rst_sp", 32'(bus.sp), 'h0FFF);
    rst_n = 1'b1;
    @(negedge clk);

    // STORE then LOAD
    present(OP_STORE, 16'h0010, 16'h0A00, 16'h0000);
    check("st_wr", 32'(bus.mem_write), 1);
    check("st_addr", 32'(bus.mem_address), 'h0010);
    check("st_wdata", 32'(bus.mem_write_data), 'h0A00);
    check("st_busy", 32'(bus.req_ready), 0);
    @(negedge clk);
    check("st_wr_drop", 32'(bus.mem_write), 0);
    check("st_ready", 32'(bus.req_ready), 1);
    check("st_sp", 32'(bus.sp), 'h0FFF);
    present(OP_LOAD, 16'h0010, 16'h0000, 16'h0000);
    check("ld_rd", 32'(bus.mem_read), 1);
    check("ld_addr", 32'(bus.mem_address), 'h0010);
    check("ld_rv_early", 32'(bus.resp_valid), 0);
    @(negedge clk);
    check("ld_rd_drop", 32'(bus.mem_read), 0);
    check("ld_rv", 32'(bus.resp_valid), 1);
    check("ld_data", 32'(bus.resp_data), 'h0A00);
    check("ld_word", 32'(bus.resp_word), 0);
    @(negedge clk);
    check("ld_rv_drop", 32'(bus.resp_valid), 0);
    check("ld_ready", 32'(bus.req_ready), 1);

    // PUSH, PUSH, POP, POP
    present(OP_PUSH, 16'h0000, 16'h1234, 16'h0000);
    check("push1_addr", 32'(bus.mem_address), 'h0FFF);
    check("push1_data", 32'(bus.mem_write_data), 'h1234);
    check("push1_sp", 32'(bus.sp), 'h0FFE);
    @(negedge clk);
    present(OP_PUSH, 16'h0000, 16'h5678, 16'h0000);
    check("push2_addr", 32'(bus.mem_address), 'h0FFE);
    check("push2_sp", 32'(bus.sp), 'h0FFD);
    @(negedge clk);
    present(OP_POP, 16'h0000, 16'h0000, 16'h0000);
    check("pop1_addr", 32'(bus.mem_address), 'h0FFE);
    check("pop1_sp", 32'(bus.sp), 'h0FFE);
    @(negedge clk);
    check("pop1_data", 32'(bus.resp_data), 'h5678);
    check("pop1_rv", 32'(bus.resp_valid), 1);
    @(negedge clk);
    present(OP_POP, 16'h0000, 16'h0000, 16'h0000);
    check("pop2_addr", 32'(bus.mem_address), 'h0FFF);
    check("pop2_sp", 32'(bus.sp), 'h0FFF);
    @(negedge clk);
    check("pop2_data", 32'(bus.resp_data), 'h1234);
    @(negedge clk);

    // PUSH2 then POP2
    present(OP_PUSH2, 16'h0000, 16'h0042, 16'h0005);
    check("p2_w1_addr", 32'(bus.mem_address), 'h0FFF);
    check("p2_w1_data", 32'(bus.mem_write_data), 'h0042);
    check("p2_sp", 32'(bus.sp), 'h0FFD);
    @(negedge clk);
    check("p2_w2_wr", 32'(bus.mem_write), 1);
    check("p2_w2_addr", 32'(bus.mem_address), 'h0FFE);
    check("p2_w2_data", 32'(bus.mem_write_data), 'h0005);
    check("p2_w2_busy", 32'(bus.req_ready), 0);
    @(negedge clk);
    check("p2_done_wr", 32'(bus.mem_write), 0);
    check("p2_done_ready", 32'(bus.req_ready), 1);
    present(OP_POP2, 16'h0000, 16'h0000, 16'h0000);
    check("q2_r1_addr", 32'(bus.mem_address), 'h0FFE);
    check("q2_sp", 32'(bus.sp), 'h0FFF);
    @(negedge clk);
    check("q2_r2_rd", 32'(bus.mem_read), 1);
    check("q2_r2_addr", 32'(bus.mem_address), 'h0FFF);
    check("q2_w0_rv", 32'(bus.resp_valid), 1);
    check("q2_w0_word", 32'(bus.resp_word), 0);
    check("q2_w0_data", 32'(bus.resp_data), 'h0005);
    @(negedge clk);
    check("q2_rd_drop", 32'(bus.mem_read), 0);
    check("q2_w1_rv", 32'(bus.resp_valid), 1);
    check("q2_w1_word", 32'(bus.resp_word), 1);
    check("q2_w1_data", 32'(bus.resp_data), 'h0042);
    @(negedge clk);
    check("q2_rv_drop", 32'(bus.resp_valid), 0);
    check("q2_ready", 32'(bus.req_ready), 1);

    // Back-to-back requests held under stall
    w0 = wr_cnt;
    bus.req_valid = 1'b1;
    bus.req_op    = OP_STORE;
    bus.req_addr  = 16'h0020;
    bus.req_data  = 16'hBEEF;
    @(negedge clk);
    bus.req_op   = OP_LOAD;
    check("bb_st_stall", 32'(bus.stall), 1);
    @(negedge clk);
    check("bb_st_stall_end", 32'(bus.stall), 0);
    @(negedge clk);
    bus.req_op   = OP_STORE;
    bus.req_addr = 16'h0021;
    bus.req_data = 16'h1111;
    check("bb_ld_rd", 32'(bus.mem_read), 1);
    check("bb_ld_stall1", 32'(bus.stall), 1);
    @(negedge clk);
    check("bb_ld_stall2", 32'(bus.stall), 1);
    check("bb_ld_data", 32'(bus.resp_data), 'hBEEF);
    @(negedge clk);
    check("bb_ld_stall_end", 32'(bus.stall), 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    check("bb_st2_addr", 32'(bus.mem_address), 'h0021);
    @(negedge clk);
    check("bb_wr_count", 32'(wr_cnt - w0), 2);
    present(OP_LOAD, 16'h0021, 16'h0000, 16'h0000);
    @(negedge clk);
    check("bb_st2_data", 32'(bus.resp_data), 'h1111);
    @(negedge clk);

    // Async reset during the second PUSH2 write
    w0 = wr_cnt;
    present(OP_PUSH2, 16'h0000, 16'hAAAA, 16'hBBBB);
    @(posedge clk);
    #1;
    check("ar_acc2_wr", 32'(bus.mem_write), 1);
    rst_n = 1'b0;
    #1;
    check("ar_wr_drop", 32'(bus.mem_write), 0);
    check("ar_sp", 32'(bus.sp), 'h0FFF);
    check("ar_ready", 32'(bus.req_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_wr_count", 32'(wr_cnt - w0), 1);
    check("ar_mem_fff", 32'(mem[12'hFFF]), 'hAAAA);
    check("ar_mem_ffe", 32'(mem[12'hFFE]), 'h0005);

    // POP with SP at its reset value
    present(OP_POP, 16'h0000, 16'h0000, 16'h0000);
`ifdef STACK_CHECK_EN
    check("sc_exc", 32'(bus.stack_exc), 1);
    check("sc_no_rd", 32'(bus.mem_read), 0);
    check("sc_sp", 32'(bus.sp), 'h0FFF);
    @(negedge clk);
    check("sc_exc_drop", 32'(bus.stack_exc), 0);
    check("sc_no_rv", 32'(bus.resp_valid), 0);
    check("sc_sp_hold", 32'(bus.sp), 'h0FFF);
`else
    check("wrap_rd", 32'(bus.mem_read), 1);
    check("wrap_addr", 32'(bus.mem_address), 'h1000);
    check("wrap_sp", 32'(bus.sp), 'h1000);
    check("wrap_exc", 32'(bus.stack_exc), 0);
    @(negedge clk);
    check("wrap_rv", 32'(bus.resp_valid), 1);
    @(negedge clk);
    check("wrap_ready", 32'(bus.req_ready), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
